int_sequencer: RTL and testbench
================================

# int_sequencer

CPU-side consumer of the interrupt controller's `int_rq`/`int_addr` pair. It owns the global interrupt enable and waits for a safe instruction boundary. At that boundary it saves the return PC and redirects fetch to a per-line vector. On return-from-interrupt it redirects back to the saved PC and then masks `int_rq` for a short holdoff, which covers the controller's registered request-clear latency. It sits inside the CPU core, between the controller outputs and the fetch/PC logic. It supports one interrupt level only; there is no nesting.

## Interface
- `PC_W`, 13: program counter width.
- `VEC_BASE`, 13'h0010: vector table base address.
- `VEC_SHIFT`, 2: log2 of the vector slot stride; vector = `VEC_BASE + (int_addr << VEC_SHIFT)`, truncated to `PC_W`.
- `HOLDOFF`, 2: cycles `int_rq` is ignored after a return, range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `int_rq`  in  1  registered request from the interrupt controller.
- `int_addr`  in  3  registered line index from the interrupt controller; valid while `int_rq`=1.
- `boundary`  in  1  CPU is at an interruptible instruction boundary this cycle.
- `pc_in`  in  PC_W  return address, valid while `boundary`=1.
- `reti`  in  1  return-from-interrupt retiring this cycle.
- `ien_wr`  in  1  software write of the global enable.
- `ien_d`  in  1  data for `ien_wr`.
- `redirect`  out  1  one-cycle fetch redirect strobe.
- `redirect_pc`  out  PC_W  redirect target; holds its last value when `redirect`=0.
- `in_isr`  out  1  handler active.
- `cur_line`  out  3  line being served; holds its last value.
- `ien`  out  1  global interrupt enable.

## Operation
- FSM states: IDLE, ARMED, ISR, HOLD. All outputs are registered.
- IDLE:
  - `ien_wr` loads `ien` from `ien_d`.
  - If `ien & int_rq`, latch `int_addr` into `cur_line` and go to ARMED.
  - Gating uses the `ien` value before any same-cycle `ien_wr`.
- ARMED:
  - If `int_rq`=0, or `ien_wr` with `ien_d`=0: abort to IDLE. No redirect, `ien` follows the write.
  - Else, on `boundary`=1:
    - `save_pc <= pc_in`, `ien <= 0`.
    - `redirect_pc <= vector(cur_line)`, `redirect <= 1`.
    - Go to ISR.
  - `cur_line` is not re-latched in ARMED; the line chosen at IDLE exit is the line served.
- ISR:
  - `in_isr`=1.
  - `ien_wr` updates `ien`, but no new take occurs.
  - On `reti`: `redirect_pc <= save_pc`, `redirect <= 1`, `ien <= 1`, holdoff counter loaded with `HOLDOFF`, go to HOLD.
  - `reti` has priority over a same-cycle `ien_wr`.
- HOLD:
  - Counter decrements each cycle; `int_rq` is ignored.
  - `ien_wr` is honoured.
  - At counter = 1, go to IDLE.
- `reti` outside ISR is ignored. `boundary` outside ARMED is ignored.
- Arithmetic: vector computed in `PC_W` bits; overflow wraps silently.

## Timing
- Reset values: `redirect`=0, `redirect_pc`=0, `in_isr`=0, `cur_line`=0, `ien`=0, state IDLE, `save_pc`=0, counter=0.
- Reset mid-ISR abandons `save_pc`; no return redirect is issued.
- Take latency:
  - `int_rq` sampled high in IDLE → ARMED next cycle.
  - `boundary` in ARMED → `redirect` high the next cycle for exactly one cycle.
  - Minimum is 2 cycles from request to redirect.
- `in_isr` rises in the same cycle as the take `redirect`. It falls in the same cycle as the return `redirect`.
- Return: `reti` at cycle t → `redirect` at t+1 → earliest new ARMED at t+1+HOLDOFF+1.
- `redirect` is never high on two consecutive cycles.
- `boundary` and `int_rq` falling in the same ARMED cycle → abort; the abort wins.

## Structure
- Package `riptide_int_pkg`: state enum `int_seq_state_t` {IDLE, ARMED, ISR, HOLD}, and default `VEC_BASE` / `VEC_SHIFT` constants shared with the assembler vector table.
- Single module. The holdoff counter is 4 bits and stays inline; no sub-module.

## Test plan
- Basic take:
  - Stimulus: `ien`=1, `int_rq`=1, `int_addr`=3; `boundary` after 2 cycles with `pc_in`=13'h0123.
  - Required: one-cycle `redirect`, `redirect_pc`=13'h001C, `in_isr`=1, `ien`=0, `cur_line`=3.
- Return and holdoff:
  - Stimulus: from ISR, pulse `reti` while `int_rq` stays 1.
  - Required: `redirect_pc`=13'h0123 one cycle later, `ien`=1, no ARMED for 2 cycles, then a re-take.
- Disabled:
  - Stimulus: `ien`=0, `int_rq`=1 for 20 cycles with repeated `boundary`.
  - Required: no `redirect`. Then `ien_wr`/`ien_d`=1 → take occurs.
- Abort:
  - Stimulus: ARMED, `int_rq` drops in the same cycle as `boundary`.
  - Required: no `redirect`, state IDLE, `ien` stays 1.
- Priority and wrap:
  - Stimulus: `reti` with simultaneous `ien_wr`/`ien_d`=0.
  - Required: `ien`=1.
  - Stimulus: `VEC_BASE`=13'h1FFC, `int_addr`=2.
  - Required: `redirect_pc`=13'h0004.
- Reset mid-ISR:
  - Stimulus: assert `rst` in ISR, then `reti`.
  - Required: all outputs at reset values, no `redirect`.

Source files
------------

// File: rtl/riptide_int_pkg.sv
// Shared interrupt-sequencer types and vector-table constants.
// The vector defaults must match the assembler's vector table layout.
package riptide_int_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      ISR,
      HOLD
   } int_seq_state_t;

   localparam logic [12:0] VEC_BASE_DFLT  = 13'h0010;
   localparam int          VEC_SHIFT_DFLT = 2;

endpackage

// File: rtl/int_sequencer.sv
// Interrupt sequencer: takes int_rq at a safe instruction boundary,
// redirects fetch to the line's vector, and returns on reti.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   int_rq       registered request from the interrupt controller
//   int_addr     line index, valid while int_rq=1
//   boundary     core is at an interruptible boundary this cycle
//   pc_in        return address, valid while boundary=1
//   reti         return-from-interrupt retiring this cycle
//   ien_wr/ien_d software write of the global enable
//   redirect     one-cycle fetch redirect strobe
//   redirect_pc  redirect target, held between strobes
//   in_isr       handler active
//   cur_line     line being served, held
//   ien          global interrupt enable
module int_sequencer
   import riptide_int_pkg::*;
#(
   parameter int              PC_W      = 13,
   parameter logic [PC_W-1:0] VEC_BASE  = PC_W'(VEC_BASE_DFLT),
   parameter int              VEC_SHIFT = VEC_SHIFT_DFLT,
   parameter int              HOLDOFF   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            int_rq,
   input  logic [2:0]      int_addr,
   input  logic            boundary,
   input  logic [PC_W-1:0] pc_in,
   input  logic            reti,
   input  logic            ien_wr,
   input  logic            ien_d,
   output logic            redirect,
   output logic [PC_W-1:0] redirect_pc,
   output logic            in_isr,
   output logic [2:0]      cur_line,
   output logic            ien
);

   // HOLDOFF is expected in 1..15; the counter is 4 bits wide.
   localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);

   int_seq_state_t state;
   int_seq_state_t state_nxt;

   logic [PC_W-1:0] save_pc;
   logic [3:0]      cnt;

   logic            redirect_nxt;
   logic [PC_W-1:0] redirect_pc_nxt;
   logic            in_isr_nxt;
   logic [2:0]      cur_line_nxt;
   logic            ien_nxt;
   logic [PC_W-1:0] save_pc_nxt;
   logic [3:0]      cnt_nxt;

   logic            want;
   logic            abort;
   logic            take;
   logic            hold_last;
   logic [PC_W-1:0] vec;

   // Gating uses the enable before any same-cycle software write.
   assign want      = ien & int_rq;
   // A dropped request or a disabling write cancels a pending take,
   // even when the boundary arrives in the same cycle.
   assign abort     = ~int_rq | (ien_wr & ~ien_d);
   assign take      = ~abort & boundary;
   assign hold_last = (cnt == 4'd1);
   // Vector arithmetic wraps silently at PC_W bits.
   assign vec       = VEC_BASE + (PC_W'(cur_line) << VEC_SHIFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (want) state_nxt = ARMED;
         end
         ARMED: begin
            if (abort)     state_nxt = IDLE;
            else if (take) state_nxt = ISR;
         end
         ISR: begin
            if (reti) state_nxt = HOLD;
         end
         HOLD: begin
            if (hold_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      redirect_nxt    = 1'b0;
      redirect_pc_nxt = redirect_pc;
      cur_line_nxt    = cur_line;
      save_pc_nxt     = save_pc;
      cnt_nxt         = cnt;
      ien_nxt         = ien_wr ? ien_d : ien;
      unique case (state)
         IDLE: begin
            if (want) cur_line_nxt = int_addr;
         end
         ARMED: begin
            if (take) begin
               save_pc_nxt     = pc_in;
               ien_nxt         = 1'b0;
               redirect_pc_nxt = vec;
               redirect_nxt    = 1'b1;
            end
         end
         ISR: begin
            // reti overrides a same-cycle enable write.
            if (reti) begin
               redirect_pc_nxt = save_pc;
               redirect_nxt    = 1'b1;
               ien_nxt         = 1'b1;
               cnt_nxt         = HOLD_INIT;
            end
         end
         HOLD: begin
            cnt_nxt = cnt - 4'd1;
         end
         default: ;
      endcase
      in_isr_nxt = (state_nxt == ISR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect    <= 1'b0;
         redirect_pc <= '0;
         in_isr      <= 1'b0;
         cur_line    <= '0;
         ien         <= 1'b0;
         save_pc     <= '0;
         cnt         <= '0;
      end else begin
         redirect    <= redirect_nxt;
         redirect_pc <= redirect_pc_nxt;
         in_isr      <= in_isr_nxt;
         cur_line    <= cur_line_nxt;
         ien         <= ien_nxt;
         save_pc     <= save_pc_nxt;
         cnt         <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_int_sequencer;

   localparam int          HOLDOFF = 2;
   localparam int          VSHIFT  = 2;
   localparam logic [12:0] BASE_D  = 13'h0010;
   localparam logic [12:0] BASE_W  = 13'h1FFC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        int_rq = 1'b0;
   logic [2:0]  int_addr = '0;
   logic        boundary = 1'b0;
   logic [12:0] pc_in = '0;
   logic        reti = 1'b0;
   logic        ien_wr = 1'b0;
   logic        ien_d = 1'b0;

   logic        redirect, in_isr, ien;
   logic [12:0] redirect_pc;
   logic [2:0]  cur_line;
   logic        w_redirect, w_in_isr, w_ien;
   logic [12:0] w_redirect_pc;
   logic [2:0]  w_cur_line;

   int total = 0;
   int bad   = 0;

   // Behavioural model: "pending" = waiting for a boundary,
   // "active" = inside handler, hold_left = cycles int_rq is ignored.
   bit          m_pend, m_act, m_ien, m_redir;
   int          m_hold;
   logic [12:0] m_rpc, m_rpc_w, m_save;
   logic [2:0]  m_line;

   always #5 clk = ~clk;

   int_sequencer #(.HOLDOFF(HOLDOFF)) dut (
      .clk(clk), .rst(rst), .int_rq(int_rq), .int_addr(int_addr),
      .boundary(boundary), .pc_in(pc_in), .reti(reti),
      .ien_wr(ien_wr), .ien_d(ien_d), .redirect(redirect),
      .redirect_pc(redirect_pc), .in_isr(in_isr),
      .cur_line(cur_line), .ien(ien)
   );

   int_sequencer #(.VEC_BASE(BASE_W), .HOLDOFF(HOLDOFF)) dut_w (
      .clk(clk), .rst(rst), .int_rq(int_rq), .int_addr(int_addr),
      .boundary(boundary), .pc_in(pc_in), .reti(reti),
      .ien_wr(ien_wr), .ien_d(ien_d), .redirect(w_redirect),
      .redirect_pc(w_redirect_pc), .in_isr(w_in_isr),
      .cur_line(w_cur_line), .ien(w_ien)
   );

   function automatic logic [12:0] vec_of(logic [12:0] base,
                                          logic [2:0] line);
      int v;
      v = int'(base) + (int'(line) * (1 << VSHIFT));
      return 13'(v % 8192);
   endfunction

   task automatic model_clock();
      bit old_ien;
      old_ien = m_ien;
      m_redir = 1'b0;
      if (rst) begin
         m_pend = 0; m_act = 0; m_hold = 0; m_ien = 0;
         m_rpc = '0; m_rpc_w = '0; m_save = '0; m_line = '0;
      end else if (m_act) begin
         if (reti) begin
            m_redir = 1; m_rpc = m_save; m_rpc_w = m_save;
            m_ien = 1; m_act = 0; m_hold = HOLDOFF;
         end else if (ien_wr) m_ien = ien_d;
      end else if (m_hold > 0) begin
         m_hold--;
         if (ien_wr) m_ien = ien_d;
      end else if (m_pend) begin
         if (!int_rq || (ien_wr && !ien_d)) begin
            m_pend = 0;
            if (ien_wr) m_ien = ien_d;
         end else if (boundary) begin
            m_save = pc_in; m_ien = 0; m_redir = 1;
            m_rpc = vec_of(BASE_D, m_line);
            m_rpc_w = vec_of(BASE_W, m_line);
            m_pend = 0; m_act = 1;
         end else if (ien_wr) m_ien = ien_d;
      end else begin
         if (ien_wr) m_ien = ien_d;
         if (old_ien && int_rq) begin
            m_line = int_addr; m_pend = 1;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic quiet();
      int_rq = 0; boundary = 0; reti = 0; ien_wr = 0;
   endtask

   task automatic test_reset();
      rst = 1; int_rq = 1; ien_wr = 1; ien_d = 1; boundary = 1;
      cyc(); cyc();
      total += 5;
      if (redirect !== 1'b0) begin bad++;
         $display("FAIL rst_redirect got=%b want=0", redirect); end
      if (redirect_pc !== 13'h0) begin bad++;
         $display("FAIL rst_rpc got=%h want=0000", redirect_pc); end
      if (in_isr !== 1'b0) begin bad++;
         $display("FAIL rst_in_isr got=%b want=0", in_isr); end
      if (cur_line !== 3'd0) begin bad++;
         $display("FAIL rst_cur_line got=%0d want=0", cur_line); end
      if (ien !== 1'b0) begin bad++;
         $display("FAIL rst_ien got=%b want=0", ien); end
      quiet(); ien_d = 0;
      rst = 0;
      cyc();
   endtask

   task automatic test_take();
      ien_wr = 1; ien_d = 1;
      cyc();
      ien_wr = 0;
      total++;
      if (ien !== 1'b1) begin bad++;
         $display("FAIL take_ien_set got=%b want=1", ien); end
      int_rq = 1; int_addr = 3;
      cyc();
      total++;
      if (cur_line !== 3'd3) begin bad++;
         $display("FAIL take_line_latch got=%0d want=3", cur_line); end
      cyc();
      boundary = 1; pc_in = 13'h0123;
      cyc();
      boundary = 0;
      total += 5;
      if (redirect !== 1'b1) begin bad++;
         $display("FAIL take_redirect got=%b want=1", redirect); end
      if (redirect_pc !== 13'h001C) begin bad++;
         $display("FAIL take_rpc got=%h want=001c", redirect_pc); end
      if (in_isr !== 1'b1) begin bad++;
         $display("FAIL take_in_isr got=%b want=1", in_isr); end
      if (ien !== 1'b0) begin bad++;
         $display("FAIL take_ien got=%b want=0", ien); end
      if (cur_line !== 3'd3) begin bad++;
         $display("FAIL take_line got=%0d want=3", cur_line); end
      cyc();
      total++;
      if (redirect !== 1'b0) begin bad++;
         $display("FAIL take_one_cycle got=%b want=0", redirect); end
   endtask

   task automatic test_return_holdoff();
      int n;
      reti = 1;
      cyc();
      reti = 0;
      total += 4;
      if (redirect !== 1'b1) begin bad++;
         $display("FAIL ret_redirect got=%b want=1", redirect); end
      if (redirect_pc !== 13'h0123) begin bad++;
         $display("FAIL ret_rpc got=%h want=0123", redirect_pc); end
      if (ien !== 1'b1) begin bad++;
         $display("FAIL ret_ien got=%b want=1", ien); end
      if (in_isr !== 1'b0) begin bad++;
         $display("FAIL ret_in_isr got=%b want=0", in_isr); end
      boundary = 1; pc_in = 13'h0456;
      n = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         if (redirect) begin n = i; break; end
      end
      boundary = 0;
      total += 2;
      if (n !== HOLDOFF + 2) begin bad++;
         $display("FAIL ret_retake_lat got=%0d want=%0d", n, HOLDOFF + 2); end
      if (redirect_pc !== 13'h001C) begin bad++;
         $display("FAIL ret_retake_rpc got=%h want=001c", redirect_pc); end
   endtask

   task automatic test_priority();
      cyc();
      reti = 1; ien_wr = 1; ien_d = 0;
      cyc();
      quiet();
      total += 2;
      if (ien !== 1'b1) begin bad++;
         $display("FAIL prio_ien got=%b want=1", ien); end
      if (redirect_pc !== 13'h0456) begin bad++;
         $display("FAIL prio_rpc got=%h want=0456", redirect_pc); end
      repeat (4) cyc();
   endtask

   task automatic test_disabled();
      int hits, n;
      ien_wr = 1; ien_d = 0;
      cyc();
      ien_wr = 0; int_rq = 1; int_addr = 6;
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         boundary = $urandom_range(0, 1) == 1;
         pc_in = 13'($urandom);
         cyc();
         if (redirect || in_isr) hits++;
      end
      total++;
      if (hits !== 0) begin bad++;
         $display("FAIL dis_no_take got=%0d want=0", hits); end
      ien_wr = 1; ien_d = 1; boundary = 1;
      cyc();
      ien_wr = 0;
      total++;
      if (redirect !== 1'b0) begin bad++;
         $display("FAIL dis_gate_old_ien got=%b want=0", redirect); end
      n = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (redirect) begin n = i; break; end
      end
      total += 2;
      if (n !== 2) begin bad++;
         $display("FAIL dis_enable_take got=%0d want=2", n); end
      if (redirect_pc !== vec_of(BASE_D, 3'd6)) begin bad++;
         $display("FAIL dis_rpc got=%h want=%h", redirect_pc,
                  vec_of(BASE_D, 3'd6)); end
      quiet(); reti = 1;
      cyc();
      reti = 0;
      repeat (4) cyc();
   endtask

   task automatic test_abort();
      int hits, n;
      int_rq = 1; int_addr = 5;
      cyc();
      total++;
      if (cur_line !== 3'd5) begin bad++;
         $display("FAIL abort_arm_line got=%0d want=5", cur_line); end
      int_rq = 0; boundary = 1;
      cyc();
      total += 3;
      if (redirect !== 1'b0) begin bad++;
         $display("FAIL abort_redirect got=%b want=0", redirect); end
      if (ien !== 1'b1) begin bad++;
         $display("FAIL abort_ien got=%b want=1", ien); end
      if (in_isr !== 1'b0) begin bad++;
         $display("FAIL abort_in_isr got=%b want=0", in_isr); end
      hits = 0;
      repeat (3) begin
         cyc();
         if (redirect) hits++;
      end
      total++;
      if (hits !== 0) begin bad++;
         $display("FAIL abort_stays_idle got=%0d want=0", hits); end
      int_rq = 1; int_addr = 1;
      n = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (redirect) begin n = i; break; end
      end
      total += 2;
      if (n !== 2) begin bad++;
         $display("FAIL abort_idle_lat got=%0d want=2", n); end
      if (redirect_pc !== 13'h0014) begin bad++;
         $display("FAIL abort_rpc got=%h want=0014", redirect_pc); end
      quiet(); reti = 1;
      cyc();
      reti = 0;
      repeat (4) cyc();
   endtask

   task automatic test_wrap();
      int n;
      int_rq = 1; int_addr = 2; boundary = 1; pc_in = 13'h0abc;
      n = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (redirect) begin n = i; break; end
      end
      quiet();
      total += 3;
      if (n !== 2) begin bad++;
         $display("FAIL wrap_lat got=%0d want=2", n); end
      if (w_redirect_pc !== 13'h0004) begin bad++;
         $display("FAIL wrap_rpc got=%h want=0004", w_redirect_pc); end
      if (redirect_pc !== 13'h0018) begin bad++;
         $display("FAIL wrap_dflt_rpc got=%h want=0018", redirect_pc); end
   endtask

   task automatic test_reset_mid_isr();
      cyc();
      total++;
      if (in_isr !== 1'b1) begin bad++;
         $display("FAIL rmid_pre_isr got=%b want=1", in_isr); end
      rst = 1;
      cyc();
      rst = 0; reti = 1;
      total += 5;
      if (redirect !== 1'b0) begin bad++;
         $display("FAIL rmid_redirect got=%b want=0", redirect); end
      if (redirect_pc !== 13'h0) begin bad++;
         $display("FAIL rmid_rpc got=%h want=0000", redirect_pc); end
      if (in_isr !== 1'b0) begin bad++;
         $display("FAIL rmid_in_isr got=%b want=0", in_isr); end
      if (cur_line !== 3'd0) begin bad++;
         $display("FAIL rmid_line got=%0d want=0", cur_line); end
      if (ien !== 1'b0) begin bad++;
         $display("FAIL rmid_ien got=%b want=0", ien); end
      cyc();
      reti = 0;
      total += 2;
      if (redirect !== 1'b0) begin bad++;
         $display("FAIL rmid_no_return got=%b want=0", redirect); end
      if (redirect_pc !== 13'h0) begin bad++;
         $display("FAIL rmid_no_return_pc got=%h want=0000", redirect_pc); end
      cyc();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst      = $urandom_range(0, 299) == 0;
         int_rq   = $urandom_range(0, 3) != 0;
         int_addr = 3'($urandom);
         boundary = $urandom_range(0, 2) == 0;
         pc_in    = 13'($urandom);
         reti     = $urandom_range(0, 5) == 0;
         ien_wr   = $urandom_range(0, 7) == 0;
         ien_d    = $urandom_range(0, 2) != 0;
         cyc();
         total += 7;
         if (redirect !== m_redir) begin bad++;
            $display("FAIL rnd_redirect i=%0d got=%b want=%b", i, redirect, m_redir); end
         if (redirect_pc !== m_rpc) begin bad++;
            $display("FAIL rnd_rpc i=%0d got=%h want=%h", i, redirect_pc, m_rpc); end
         if (in_isr !== m_act) begin bad++;
            $display("FAIL rnd_in_isr i=%0d got=%b want=%b", i, in_isr, m_act); end
         if (cur_line !== m_line) begin bad++;
            $display("FAIL rnd_line i=%0d got=%0d want=%0d", i, cur_line, m_line); end
         if (ien !== m_ien) begin bad++;
            $display("FAIL rnd_ien i=%0d got=%b want=%b", i, ien, m_ien); end
         if (w_redirect_pc !== m_rpc_w) begin bad++;
            $display("FAIL rnd_w_rpc i=%0d got=%h want=%h", i, w_redirect_pc, m_rpc_w); end
         if ({w_redirect, w_in_isr, w_cur_line, w_ien} !==
             {m_redir, m_act, m_line, m_ien}) begin bad++;
            $display("FAIL rnd_w_ctl i=%0d got=%b want=%b", i,
                     {w_redirect, w_in_isr, w_cur_line, w_ien},
                     {m_redir, m_act, m_line, m_ien}); end
      end
      quiet(); rst = 0;
   endtask

   initial begin
      test_reset();
      test_take();
      test_return_holdoff();
      test_priority();
      test_disabled();
      test_abort();
      test_wrap();
      test_reset_mid_isr();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
